// File: rtl/pipreg_elastic_if.sv
// Handshake bundle for one elastic pipeline stage: upstream accept side, downstream
// present side, flush and occupancy. The stage uses the slave modport.
interface pipreg_elastic_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       occupancy;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipreg_elastic.sv
// Elastic pipeline stage: main + skid buffer under valid/ready, all outputs from flops,
// synchronous flush, optional zeroing of the payload whenever the stage is empty.
module pipreg_elastic #(
  parameter int unsigned WIDTH          = 32,
  parameter bit          CLEAR_ON_EMPTY = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  pipreg_elastic_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             in_fire;
  logic             out_fire;

  // Handshake events only ever see registered ready/valid, so no comb path to outputs.
  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (bus.flush) begin
      // An out_fire here is already consumed downstream; nothing left to move.
      state_d = EMPTY;
      if (CLEAR_ON_EMPTY) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = bus.in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = bus.in_data;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = bus.in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
            if (CLEAR_ON_EMPTY) main_d = '0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign bus.occupancy = 2'(state_q);

endmodule

// File: tb/tb_pipreg_elastic.sv
// Directed and randomised checks of pipreg_elastic with both payload-clear settings
// and with 1-bit and 64-bit payloads.
module tb_pipreg_elastic;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  pipreg_elastic_if #(.WIDTH(32)) if_a ();
  pipreg_elastic_if #(.WIDTH(32)) if_b ();
  pipreg_elastic_if #(.WIDTH(1))  if_w1 ();
  pipreg_elastic_if #(.WIDTH(64)) if_w64 ();

  // if_b mirrors the stimulus of if_a so the two clear settings can be compared.
  assign if_b.in_valid  = if_a.in_valid;
  assign if_b.in_data   = if_a.in_data;
  assign if_b.out_ready = if_a.out_ready;
  assign if_b.flush     = if_a.flush;

  pipreg_elastic #(.WIDTH(32), .CLEAR_ON_EMPTY(1'b1)) dut_a   (.clk(clk), .reset(rst_n), .bus(if_a));
  pipreg_elastic #(.WIDTH(32), .CLEAR_ON_EMPTY(1'b0)) dut_b   (.clk(clk), .reset(rst_n), .bus(if_b));
  pipreg_elastic #(.WIDTH(1),  .CLEAR_ON_EMPTY(1'b1)) dut_w1  (.clk(clk), .reset(rst_n), .bus(if_w1));
  pipreg_elastic #(.WIDTH(64), .CLEAR_ON_EMPTY(1'b1)) dut_w64 (.clk(clk), .reset(rst_n), .bus(if_w64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    if_a.in_valid  = 1'b0;
    if_a.in_data   = 32'h0;
    if_a.out_ready = 1'b0;
    if_a.flush     = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", if_a.out_valid); end
    checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", if_a.in_ready); end
    checks++; if (if_a.occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", if_a.occupancy); end
    checks++; if (if_a.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%0h exp=0", if_a.out_data); end
    checks++; if (if_b.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data_noclr got=%0h exp=0", if_b.out_data); end
    checks++; if (if_w64.in_ready !== 1'b1) begin errors++; $display("FAIL reset_w64_in_ready got=%0b exp=1", if_w64.in_ready); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp;
    if_a.out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      exp = 32'(k);
      if_a.in_valid = 1'b1;
      if_a.in_data  = exp;
      step();
      checks++; if (if_a.out_data !== exp) begin errors++; $display("FAIL stream_data%0d got=%0h exp=%0h", k, if_a.out_data, exp); end
      checks++; if (if_a.occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ%0d got=%0d exp=1", k, if_a.occupancy); end
      checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready%0d got=%0b exp=1", k, if_a.in_ready); end
      checks++; if (if_a.out_valid !== 1'b1) begin errors++; $display("FAIL stream_out_valid%0d got=%0b exp=1", k, if_a.out_valid); end
    end
    // Drain the last payload: clear setting zeroes out_data, the other keeps 0x3.
    if_a.in_valid = 1'b0;
    step();
    checks++; if (if_a.occupancy !== 2'd0) begin errors++; $display("FAIL drain_occ got=%0d exp=0", if_a.occupancy); end
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid got=%0b exp=0", if_a.out_valid); end
    checks++; if (if_a.out_data !== 32'h0) begin errors++; $display("FAIL drain_clear_data got=%0h exp=0", if_a.out_data); end
    checks++; if (if_b.out_data !== 32'h3) begin errors++; $display("FAIL drain_hold_data got=%0h exp=3", if_b.out_data); end
    checks++; if (if_b.out_valid !== 1'b0) begin errors++; $display("FAIL drain_hold_valid got=%0b exp=0", if_b.out_valid); end
    idle_a();
  endtask

  task automatic test_backpressure();
    if_a.out_ready = 1'b1;
    if_a.in_valid  = 1'b1;
    if_a.in_data   = 32'hA;
    step();
    checks++; if (if_a.out_data !== 32'hA) begin errors++; $display("FAIL bp_first got=%0h exp=a", if_a.out_data); end
    if_a.out_ready = 1'b0;
    if_a.in_data   = 32'hB;
    step();
    checks++; if (if_a.occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ_full got=%0d exp=2", if_a.occupancy); end
    checks++; if (if_a.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%0b exp=0", if_a.in_ready); end
    checks++; if (if_a.out_data !== 32'hA) begin errors++; $display("FAIL bp_hold_a got=%0h exp=a", if_a.out_data); end
    if_a.in_data = 32'hC;
    step();
    checks++; if (if_a.occupancy !== 2'd2) begin errors++; $display("FAIL bp_c_held_occ got=%0d exp=2", if_a.occupancy); end
    checks++; if (if_a.out_data !== 32'hA) begin errors++; $display("FAIL bp_c_held_data got=%0h exp=a", if_a.out_data); end
    if_a.out_ready = 1'b1;
    step();
    checks++; if (if_a.out_data !== 32'hB) begin errors++; $display("FAIL bp_release_b got=%0h exp=b", if_a.out_data); end
    checks++; if (if_a.occupancy !== 2'd1) begin errors++; $display("FAIL bp_release_occ got=%0d exp=1", if_a.occupancy); end
    checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0b exp=1", if_a.in_ready); end
    step();
    checks++; if (if_a.out_data !== 32'hC) begin errors++; $display("FAIL bp_c_out got=%0h exp=c", if_a.out_data); end
    checks++; if (if_a.occupancy !== 2'd1) begin errors++; $display("FAIL bp_c_occ got=%0d exp=1", if_a.occupancy); end
    if_a.in_valid = 1'b0;
    step();
    checks++; if (if_a.occupancy !== 2'd0) begin errors++; $display("FAIL bp_empty got=%0d exp=0", if_a.occupancy); end
    idle_a();
  endtask

  task automatic test_flush();
    if_a.in_valid = 1'b1;
    if_a.in_data  = 32'h11;
    step();
    if_a.in_data  = 32'h22;
    step();
    checks++; if (if_a.occupancy !== 2'd2) begin errors++; $display("FAIL flush_prefill got=%0d exp=2", if_a.occupancy); end
    if_a.in_data = 32'hD;
    if_a.flush   = 1'b1;
    step();
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%0b exp=0", if_a.out_valid); end
    checks++; if (if_a.out_data !== 32'h0) begin errors++; $display("FAIL flush_out_data got=%0h exp=0", if_a.out_data); end
    checks++; if (if_a.occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ got=%0d exp=0", if_a.occupancy); end
    checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%0b exp=1", if_a.in_ready); end
    checks++; if (if_b.out_data !== 32'h11) begin errors++; $display("FAIL flush_noclr_data got=%0h exp=11", if_b.out_data); end
    // Held flush keeps the stage empty even with a payload offered.
    if_a.in_data = 32'hE;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (if_a.occupancy !== 2'd0) begin errors++; $display("FAIL flush_hold_occ%0d got=%0d exp=0", k, if_a.occupancy); end
    end
    if_a.flush     = 1'b0;
    if_a.in_valid  = 1'b0;
    if_a.out_ready = 1'b1;
    step();
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got=%0b exp=0", if_a.out_valid); end
    idle_a();
  endtask

  task automatic test_async_reset();
    if_a.in_valid = 1'b1;
    if_a.in_data  = 32'h31;
    step();
    if_a.in_data  = 32'h32;
    step();
    if_a.in_valid = 1'b0;
    checks++; if (if_a.occupancy !== 2'd2) begin errors++; $display("FAIL areset_prefill got=%0d exp=2", if_a.occupancy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got=%0b exp=0", if_a.out_valid); end
    checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got=%0b exp=1", if_a.in_ready); end
    checks++; if (if_a.occupancy !== 2'd0) begin errors++; $display("FAIL areset_occ got=%0d exp=0", if_a.occupancy); end
    checks++; if (if_a.out_data !== 32'h0) begin errors++; $display("FAIL areset_out_data got=%0h exp=0", if_a.out_data); end
    checks++; if (if_b.out_data !== 32'h0) begin errors++; $display("FAIL areset_noclr_data got=%0h exp=0", if_b.out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (if_a.occupancy !== 2'd0) begin errors++; $display("FAIL areset_after got=%0d exp=0", if_a.occupancy); end
    idle_a();
  endtask

  task automatic test_random();
    logic [63:0] q64[$];
    logic        q1[$];
    logic        hold64, hold1;
    logic        fire_in, fire_out;
    int          sz;
    hold64 = 1'b0;
    hold1  = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      // 64-bit instance: compare outputs with the reference queue, then drive.
      sz = q64.size();
      checks++; if (if_w64.occupancy !== 2'(sz)) begin errors++; $display("FAIL rnd64_occ c%0d got=%0d exp=%0d", cyc, if_w64.occupancy, sz); end
      checks++; if (if_w64.out_valid !== (sz != 0)) begin errors++; $display("FAIL rnd64_valid c%0d got=%0b exp=%0b", cyc, if_w64.out_valid, sz != 0); end
      checks++; if (if_w64.in_ready !== (sz < 2)) begin errors++; $display("FAIL rnd64_ready c%0d got=%0b exp=%0b", cyc, if_w64.in_ready, sz < 2); end
      checks++; if (if_w64.out_data !== ((sz != 0) ? q64[0] : 64'h0)) begin errors++; $display("FAIL rnd64_data c%0d got=%0h exp=%0h", cyc, if_w64.out_data, (sz != 0) ? q64[0] : 64'h0); end
      if (!hold64) begin
        if_w64.in_valid = ($urandom_range(0, 3) != 0);
        if_w64.in_data  = {$urandom, $urandom};
      end
      if_w64.out_ready = ($urandom_range(0, 2) != 0);
      if_w64.flush     = ($urandom_range(0, 49) == 0);
      fire_in  = if_w64.in_valid & (sz < 2);
      fire_out = (sz != 0) & if_w64.out_ready;
      hold64   = if_w64.in_valid & !fire_in;
      if (fire_out) void'(q64.pop_front());
      if (if_w64.flush) q64.delete();
      else if (fire_in) q64.push_back(if_w64.in_data);

      // 1-bit instance, independent stimulus.
      sz = q1.size();
      checks++; if (if_w1.occupancy !== 2'(sz)) begin errors++; $display("FAIL rnd1_occ c%0d got=%0d exp=%0d", cyc, if_w1.occupancy, sz); end
      checks++; if (if_w1.out_valid !== (sz != 0)) begin errors++; $display("FAIL rnd1_valid c%0d got=%0b exp=%0b", cyc, if_w1.out_valid, sz != 0); end
      checks++; if (if_w1.in_ready !== (sz < 2)) begin errors++; $display("FAIL rnd1_ready c%0d got=%0b exp=%0b", cyc, if_w1.in_ready, sz < 2); end
      checks++; if (if_w1.out_data !== ((sz != 0) ? q1[0] : 1'b0)) begin errors++; $display("FAIL rnd1_data c%0d got=%0b exp=%0b", cyc, if_w1.out_data, (sz != 0) ? q1[0] : 1'b0); end
      if (!hold1) begin
        if_w1.in_valid = ($urandom_range(0, 1) != 0);
        if_w1.in_data  = 1'($urandom);
      end
      if_w1.out_ready = ($urandom_range(0, 1) != 0);
      if_w1.flush     = ($urandom_range(0, 63) == 0);
      fire_in  = if_w1.in_valid & (sz < 2);
      fire_out = (sz != 0) & if_w1.out_ready;
      hold1    = if_w1.in_valid & !fire_in;
      if (fire_out) void'(q1.pop_front());
      if (if_w1.flush) q1.delete();
      else if (fire_in) q1.push_back(if_w1.in_data);

      step();
    end
    if_w64.in_valid = 1'b0;
    if_w64.flush    = 1'b0;
    if_w1.in_valid  = 1'b0;
    if_w1.flush     = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle_a();
    if_w1.in_valid   = 1'b0;
    if_w1.in_data    = 1'b0;
    if_w1.out_ready  = 1'b0;
    if_w1.flush      = 1'b0;
    if_w64.in_valid  = 1'b0;
    if_w64.in_data   = 64'h0;
    if_w64.out_ready = 1'b0;
    if_w64.flush     = 1'b0;
    #12;
    rst_n = 1'b1;
    #1;
    test_reset();
    step();
    test_streaming();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipreg_elastic.md
# pipreg_elastic

Parametrised, handshaked successor to the fixed-width stall/clear pipeline registers. One stage of elastic pipeline: a WIDTH-bit payload is moved from an upstream stage to a downstream stage under a valid/ready handshake, with a two-entry (main + skid) buffer so that back-pressure never drops data and never creates a combinational ready path. It also provides a synchronous flush that squashes in-flight payloads. The block is instantiated between every pair of stages of the next-generation pipelined MIPS datapath, replacing per-stage hand-written registers.

## Interface
- WIDTH, default 32: payload width in bits; legal range 1..256.
- CLEAR_ON_EMPTY, default 1:
  - 1: `out_data` is forced to 0 whenever the stage holds no entry, giving a bubble of all-zero control bits.
  - 0: `out_data` holds its last value.

- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  upstream presents a payload.
- in_ready  output  1  stage can accept a payload this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  stage presents a payload downstream.
- out_ready  input  1  downstream accepts the payload this cycle.
- out_data  output  WIDTH  payload presented downstream.
- flush  input  1  synchronous squash of all held entries.
- occupancy  output  2  number of held entries (0, 1 or 2).

## Operation
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage:
  - `main` register drives `out_data`.
  - `skid` register holds the second entry.
- States, with occupancy equal to the state value:
  - EMPTY (0)
  - ONE (1)
  - FULL (2)
- Transitions when flush = 0:
  - EMPTY, in_fire: go to ONE; main <= in_data.
  - ONE, in_fire & out_fire: stay in ONE; main <= in_data.
  - ONE, in_fire & !out_fire: go to FULL; skid <= in_data.
  - ONE, !in_fire & out_fire: go to EMPTY. If CLEAR_ON_EMPTY=1, main <= 0.
  - FULL, out_fire: go to ONE; main <= skid. in_fire is impossible in FULL.
  - Any other combination: hold state and registers.
- Flush behaviour:
  - flush = 1 at a rising edge forces state to EMPTY.
  - If CLEAR_ON_EMPTY=1, main and skid are cleared to 0.
  - A payload offered with in_fire in the same cycle is discarded.
  - An out_fire in the flush cycle still counts as consumed by downstream; the stage takes no further action on it.
- Outputs are pure functions of registered state, with no combinational input-to-output path:
  - in_valid and out_ready never combinationally affect in_ready.
  - in_data never combinationally affects out_data.
  - Output equations: out_valid = (state != EMPTY); in_ready = (state != FULL).
- Ordering: strict FIFO. Payloads leave in acceptance order and are never duplicated.
- Protocol rules:
  - Upstream must hold in_valid and in_data stable until in_fire.
  - The stage likewise holds out_valid and out_data stable until out_fire or flush.
- Reset (reset = 0):
  - State goes to EMPTY immediately, asynchronously.
  - main and skid are cleared to 0 regardless of CLEAR_ON_EMPTY.
  - Reset values of outputs: out_valid=0, in_ready=1, out_data=0, occupancy=0.

## Timing
- Latency: a payload accepted at edge N is visible on out_data/out_valid after edge N, i.e. in cycle N+1.
- Throughput: one payload per cycle while out_ready stays high.
- Back-pressure:
  - After out_ready falls, the stage absorbs at most one further payload, into skid.
  - in_ready drops in the cycle after the stage becomes FULL.
- Release from FULL:
  - The first out_fire releases the main entry, and skid moves to main at that edge.
  - in_ready rises in the following cycle.
- Flush takes effect at the edge where it is sampled:
  - Next cycle: out_valid=0 and in_ready=1.
  - flush held high for several cycles keeps the stage EMPTY and accepts nothing.
- Reset deassertion: the first accepting edge is the first rising edge after reset returns to 1.

## Test plan
- Streaming, WIDTH=32, out_ready=1, in_valid=1: payloads 0x1,0x2,0x3 applied on consecutive cycles → out_data shows 0x1,0x2,0x3 one cycle later; occupancy stays 1; in_ready stays 1.
- Back-pressure: accept 0xA, then drop out_ready while offering 0xB, 0xC → 0xB goes to skid; occupancy=2; in_ready=0; 0xC is held upstream. Raise out_ready → 0xA, 0xB, 0xC emerge in order with no loss.
- Flush while FULL, CLEAR_ON_EMPTY=1, with in_valid=1 offering 0xD → next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1; 0xD never appears.
- Drain to empty: CLEAR_ON_EMPTY=0 leaves out_data at the last value with out_valid=0; CLEAR_ON_EMPTY=1 gives out_data=0.
- Asynchronous reset mid-transfer while FULL: pull reset low between edges → out_valid=0, in_ready=1, occupancy=0, out_data=0 without any clock edge.
- Random valid/ready, 10k cycles, WIDTH=1 and WIDTH=64, checked against a scoreboard:
  - Output sequence equals the accepted sequence minus flushed entries.
  - Stability rule holds.
  - occupancy never exceeds 2.
